// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: 128KB main RAM plus memory-mapped UART RX/TX,
// a free-running cycle counter with coherent dword snapshot, and a sticky program-stop flag.
module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  // Address decode
  logic                  io_sel;
  logic                  io_rx;
  logic                  io_cnt;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  unused_addr;

  assign io_sel      = (mem_a[17:16] == 2'b11);
  assign io_rx       = io_sel && (mem_a[15:0] == 16'h0000);
  assign io_cnt      = io_sel && (mem_a[15:2] == 14'h0001);
  assign ram_addr    = mem_a[ADDR_WIDTH-1:0];
  assign unused_addr = ^mem_a;

  // Main RAM
  logic [7:0] ram [2**ADDR_WIDTH];
  logic [7:0] ram_rd_q;
  logic       ram_sel_q;

  // NOTE: storage arrays carry no reset so they map onto block RAM; only the control
  // flops around them are reset, which is enough to force clean outputs.
  always_ff @(posedge clk) begin
    if (mem_wr && !io_sel) ram[ram_addr] <= mem_dout;
    ram_rd_q <= ram[ram_addr];
  end

  // Cycle counter, snapshot of its upper bytes, IO read data and sticky flags
  logic [31:0] cnt_q;
  logic [23:0] snap_q, snap_d;
  logic [7:0]  din_io_q, din_io_d;
  logic        stop_q, stop_d;
  logic        push;
  logic [7:0]  push_byte;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    snap_d    = snap_q;
    din_io_d  = '0;
    stop_d    = stop_q;
    push      = 1'b0;
    push_byte = '0;
    if (mem_wr) begin
      if (io_rx) begin
        push      = (mem_dout != 8'h00);
        push_byte = mem_dout;
      end else if (io_cnt && (mem_a[1:0] == 2'b00)) begin
        stop_d = 1'b1;
        push   = 1'b1;
      end
    end else if (io_rx) begin
      din_io_d = rx_valid ? rx_data : 8'h00;
    end else if (io_cnt) begin
      case (mem_a[1:0])
        2'd0: begin
          din_io_d = cnt_q[7:0];
          snap_d   = cnt_q[31:8];
        end
        2'd1:    din_io_d = snap_q[7:0];
        2'd2:    din_io_d = snap_q[15:8];
        default: din_io_d = snap_q[23:16];
      endcase
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      snap_q    <= '0;
      din_io_q  <= '0;
      ram_sel_q <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_q + 32'd1;
      snap_q    <= snap_d;
      din_io_q  <= din_io_d;
      ram_sel_q <= !mem_wr && !io_sel;
      stop_q    <= stop_d;
    end
  end

  assign mem_din      = ram_sel_q ? ram_rd_q : din_io_q;
  assign program_stop = stop_q;
  assign rx_pop       = rst && !mem_wr && io_rx && rx_valid;

  // TX FIFO
  logic [7:0]    fifo [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign full    = (count_q == CW'(TX_DEPTH));
  assign pop     = tx_valid && tx_ready;
  // A pop frees the slot the simultaneous push lands in, so push at full is legal then.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo[wr_ptr_q] <= push_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push && !push_ok) ovf_q <= 1'b1;
    end
  end

  assign tx_valid       = (count_q != '0);
  assign tx_data        = tx_valid ? fifo[rd_ptr_q] : 8'h00;
  assign tx_overflow    = ovf_q;
  assign io_buffer_full = (count_q >= CW'(TX_DEPTH - 2));

endmodule
